// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control sequencer for a reduced RV32 datapath (R, I-ALU, LW, SW, JAL, B-type).
// Optional feature macro: PERF_COUNTERS_EN adds cycle_count / instret_count outputs.
module multicycle_control_fsm #(
  parameter int unsigned MEM_WAIT_MAX = 32'd15
`ifdef PERF_COUNTERS_EN
  ,
  parameter int unsigned COUNT_W = 32'd32
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] OPcode,
  input  logic [2:0] func3,
  input  logic       Flag,
  input  logic       imem_valid,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       pc_en,
  output logic       sel_bit,
  output logic       reg_write_en,
  output logic       mux1_load_bit,
  output logic       mem_write_en,
  output logic       mem_read,
  output logic [1:0] sel_bit_PC,
  output logic       write_mux_sel,
  output logic       halted,
  output logic       illegal_instr,
  output logic       bus_error
`ifdef PERF_COUNTERS_EN
  ,
  output logic [COUNT_W-1:0] cycle_count,
  output logic [COUNT_W-1:0] instret_count
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    OP_ILL = 3'd0,
    OP_R   = 3'd1,
    OP_I   = 3'd2,
    OP_LW  = 3'd3,
    OP_SW  = 3'd4,
    OP_JAL = 3'd5,
    OP_BR  = 3'd6
  } op_e;

  localparam logic [7:0] WAIT_MAX  = 8'(MEM_WAIT_MAX);
  localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 32'd1);

  function automatic op_e decode_op(input logic [6:0] opc);
    op_e op;
    case (opc)
      7'b0110011: op = OP_R;
      7'b0010011: op = OP_I;
      7'b0000011: op = OP_LW;
      7'b0100011: op = OP_SW;
      7'b1101111: op = OP_JAL;
      7'b1100011: op = OP_BR;
      default:    op = OP_ILL;
    endcase
    return op;
  endfunction

  function automatic logic br_legal(input logic [2:0] f3);
    logic ok;
    case (f3)
      3'b000, 3'b001, 3'b100, 3'b101: ok = 1'b1;
      default:                        ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic br_taken(input logic [2:0] f3, input logic flag);
    logic tk;
    case (f3)
      3'b000:  tk = flag;
      3'b001:  tk = ~flag;
      3'b100:  tk = flag;
      3'b101:  tk = ~flag;
      default: tk = 1'b0;
    endcase
    return tk;
  endfunction

  state_e     state_q, state_d;
  op_e        op_q, op_d, dec_op_s, op_cur_s;
  logic [2:0] f3_q, f3_d;
  logic [7:0] wait_q, wait_d;
  logic       illegal_q, illegal_d;
  logic       bus_err_q, bus_err_d;
  logic       wait_exp_s;

  logic       imem_req_s, pc_en_s, rwe_s, mwe_s, mrd_s;
  logic       sel_bit_s, wms_s, m1_s;
  logic [1:0] sel_pc_s;

  assign dec_op_s   = decode_op(OPcode);
  assign wait_exp_s = (wait_q >= WAIT_LAST);

  // Next-state, latched control word, wait counter and sticky fault flags
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    f3_d      = f3_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    case (state_q)
      S_FETCH: begin
        if (imem_valid) begin
          state_d = S_DECODE;
        end else if (wait_exp_s) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        op_d = dec_op_s;
        f3_d = func3;
        if (dec_op_s == OP_ILL) begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (op_q)
          OP_R, OP_I, OP_JAL: state_d = S_WB;
          OP_LW, OP_SW:       state_d = S_MEM;
          OP_BR: begin
            if (br_legal(f3_q)) begin
              state_d = S_FETCH;
            end else begin
              state_d   = S_HALT;
              illegal_d = 1'b1;
            end
          end
          default: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        if (dmem_ready) begin
          state_d = (op_q == OP_LW) ? S_WB : S_FETCH;
        end else if (wait_exp_s) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end else begin
          state_d = S_MEM;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase

    // Counter restarts on any state change and saturates while waiting
    if (state_d != state_q) begin
      wait_d = 8'd0;
    end else if (wait_q == WAIT_MAX) begin
      wait_d = wait_q;
    end else begin
      wait_d = wait_q + 8'd1;
    end
  end

  // Datapath control decode from current state and latched instruction class
  always_comb begin
    op_cur_s   = (state_q == S_DECODE) ? dec_op_s : op_q;
    imem_req_s = 1'b0;
    pc_en_s    = 1'b0;
    rwe_s      = 1'b0;
    mwe_s      = 1'b0;
    mrd_s      = 1'b0;
    sel_pc_s   = 2'd0;
    if (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
      sel_bit_s = (op_cur_s inside {OP_I, OP_LW, OP_SW});
      wms_s     = (op_cur_s inside {OP_R, OP_I, OP_LW});
      m1_s      = (op_cur_s == OP_LW);
    end else begin
      sel_bit_s = 1'b0;
      wms_s     = 1'b0;
      m1_s      = 1'b0;
    end
    case (state_q)
      S_FETCH: imem_req_s = 1'b1;
      S_EXEC: begin
        if ((op_q == OP_BR) && br_legal(f3_q)) begin
          pc_en_s  = 1'b1;
          sel_pc_s = br_taken(f3_q, Flag) ? 2'd2 : 2'd0;
        end else begin
          pc_en_s  = 1'b0;
          sel_pc_s = 2'd0;
        end
      end
      S_MEM: begin
        mrd_s   = (op_q == OP_LW);
        mwe_s   = (op_q == OP_SW);
        pc_en_s = (op_q == OP_SW) && dmem_ready;
      end
      S_WB: begin
        rwe_s    = 1'b1;
        pc_en_s  = 1'b1;
        mrd_s    = (op_q == OP_LW);
        sel_pc_s = (op_q == OP_JAL) ? 2'd1 : 2'd0;
      end
      default: imem_req_s = 1'b0;
    endcase
  end

`ifdef PERF_COUNTERS_EN
  logic [COUNT_W-1:0] cycle_q, cycle_d, instret_q, instret_d;

  // Performance counter increments; both wrap naturally
  always_comb begin
    if (state_q == S_HALT) begin
      cycle_d = cycle_q;
    end else begin
      cycle_d = cycle_q + COUNT_W'(1);
    end
    if (pc_en_s) begin
      instret_d = instret_q + COUNT_W'(1);
    end else begin
      instret_d = instret_q;
    end
  end

  assign cycle_count   = cycle_q;
  assign instret_count = instret_q;
`endif

  // Sequencer state register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      op_q      <= OP_ILL;
      f3_q      <= 3'd0;
      wait_q    <= 8'd0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
`ifdef PERF_COUNTERS_EN
      cycle_q   <= '0;
      instret_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      f3_q      <= f3_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
`ifdef PERF_COUNTERS_EN
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
`endif
    end
  end

  // Write strobes are masked by reset so a mid-instruction reset cannot commit anything
  assign imem_req      = imem_req_s & ~reset;
  assign pc_en         = pc_en_s & ~reset;
  assign reg_write_en  = rwe_s & ~reset;
  assign mem_write_en  = mwe_s & ~reset;
  assign mem_read      = mrd_s;
  assign sel_bit       = sel_bit_s;
  assign write_mux_sel = wms_s;
  assign mux1_load_bit = m1_s;
  assign sel_bit_PC    = sel_pc_s;
  assign halted        = (state_q == S_HALT);
  assign illegal_instr = illegal_q;
  assign bus_error     = bus_err_q;

endmodule
